// File: rtl/wb_stage_if.sv
// Writeback-stage bundle: MEM-stage inputs, late-unit valid/ready port, write port and hazard outputs.
// No storage; purely a signal grouping.
// master = pipeline / late unit / hazard side, slave = wb_stage.
interface wb_stage_if;
  // MEM-stage side
  logic        stall_w;
  logic        flush_w;
  logic        regwrite_m;
  logic [1:0]  result_src_m;
  logic [4:0]  rd_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m;
  logic [31:0] read_data_m;
  logic [31:0] pc_plus_4_m;
  // late-unit result port
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  // register-file write port and forwarding/hazard outputs
  logic        writeback_control;
  logic [4:0]  rd;
  logic [31:0] writeback_data;
  logic [31:0] result_w;
  logic [4:0]  rd_w;
  logic        regwrite_w;
  logic [31:0] lu_pending_mask;
  logic        stall_req;

  modport master (
    output stall_w, flush_w, regwrite_m, result_src_m, rd_m, funct3_m,
           alu_result_m, read_data_m, pc_plus_4_m, lu_valid, lu_rd, lu_data,
    input  lu_ready, writeback_control, rd, writeback_data, result_w, rd_w,
           regwrite_w, lu_pending_mask, stall_req
  );

  modport slave (
    input  stall_w, flush_w, regwrite_m, result_src_m, rd_m, funct3_m,
           alu_result_m, read_data_m, pc_plus_4_m, lu_valid, lu_rd, lu_data,
    output lu_ready, writeback_control, rd, writeback_data, result_w, rd_w,
           regwrite_w, lu_pending_mask, stall_req
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, result select, write-port merge of a late-unit FIFO.
// Latency: M-stage result on write port 1 cycle after capture; late-unit result >= 1 cycle.
// Backpressure: lu_ready = FIFO not full (registered); stall_req after STARVE_LIMIT waiting cycles.
// Optional: define WB_LOAD_EXT_EN to extract/extend byte and halfword loads here.
module wb_stage #(
  parameter int LU_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic        clk,
  input logic        reset,
  wb_stage_if.slave  wb_if
);
  localparam int PW = $clog2(LU_DEPTH);

  // MEM/WB pipeline register
  logic        regwrite_q, regwrite_d;
  logic [1:0]  src_q, src_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] load_val;
  logic [31:0] result;

  // late-unit FIFO: a valid bit per slot makes full/empty/mask trivial
  logic [4:0]          fifo_rd_q  [LU_DEPTH];
  logic [31:0]         fifo_dat_q [LU_DEPTH];
  logic [LU_DEPTH-1:0] fifo_vld_q, fifo_vld_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]          starve_q, starve_d;
  logic                pipe_owns, fifo_empty, push, pop;

  // next-state for MEM/WB: flush beats stall beats load
  always_comb begin
    regwrite_d = regwrite_q;
    src_d      = src_q;
    rd_d       = rd_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    pc4_d      = pc4_q;
    if (wb_if.flush_w) begin
      regwrite_d = 1'b0;
    end else if (!wb_if.stall_w) begin
      regwrite_d = wb_if.regwrite_m;
      src_d      = wb_if.result_src_m;
      rd_d       = wb_if.rd_m;
      alu_d      = wb_if.alu_result_m;
      rdata_d    = wb_if.read_data_m;
      pc4_d      = wb_if.pc_plus_4_m;
    end
  end

  // MEM/WB register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_q <= 1'b0;
      src_q      <= 2'b00;
      rd_q       <= 5'd0;
      alu_q      <= 32'd0;
      rdata_q    <= 32'd0;
      pc4_q      <= 32'd0;
    end else begin
      regwrite_q <= regwrite_d;
      src_q      <= src_d;
      rd_q       <= rd_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      pc4_q      <= pc4_d;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0]  funct3_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // funct3 shares the MEM/WB hold/load behaviour; its value is irrelevant after a flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  funct3_q <= 3'b000;
    else if (!wb_if.flush_w && !wb_if.stall_w)   funct3_q <= wb_if.funct3_m;
  end

  // byte/halfword extraction; offset-3 halfword only has one byte left in the word
  always_comb begin
    case (alu_q[1:0])
      2'd0:    begin ld_byte = rdata_q[7:0];   ld_half = rdata_q[15:0];          end
      2'd1:    begin ld_byte = rdata_q[15:8];  ld_half = rdata_q[23:8];          end
      2'd2:    begin ld_byte = rdata_q[23:16]; ld_half = rdata_q[31:16];         end
      default: begin ld_byte = rdata_q[31:24]; ld_half = {8'h00, rdata_q[31:24]}; end
    endcase
    case (funct3_q)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'd0, ld_byte};
      3'b101:  load_val = {16'd0, ld_half};
      default: load_val = rdata_q;
    endcase
  end
`else
  // memory already extracted the load; funct3 carries no information here
  logic unused_funct3;
  assign unused_funct3 = ^wb_if.funct3_m;
  assign load_val      = rdata_q;
`endif

  // architectural result select; reserved encoding falls back to ALU
  always_comb begin
    case (src_q)
      2'b01:   result = load_val;
      2'b10:   result = pc4_q;
      default: result = alu_q;
    endcase
  end

  assign wb_if.result_w   = result;
  assign wb_if.rd_w       = rd_q;
  assign wb_if.regwrite_w = regwrite_q;

  // a pipeline write to x0 is idle time for the port
  assign pipe_owns      = regwrite_q && (rd_q != 5'd0);
  assign fifo_empty     = !fifo_vld_q[rd_ptr_q];
  assign pop            = !pipe_owns && !fifo_empty;
  assign wb_if.lu_ready = !fifo_vld_q[wr_ptr_q];
  assign push           = wb_if.lu_valid && wb_if.lu_ready && (wb_if.lu_rd != 5'd0);
  assign wb_if.stall_req = (starve_q >= 4'(STARVE_LIMIT));

  // FIFO control next-state and head starvation counter
  always_comb begin
    fifo_vld_d = fifo_vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    starve_d   = starve_q;
    if (pop) begin
      fifo_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + PW'(1);
    end
    if (push) begin
      fifo_vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop || fifo_empty)      starve_d = 4'd0;
    else if (starve_q != 4'hF)  starve_d = starve_q + 4'd1;
  end

  // FIFO control state; reset drops every entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= 4'd0;
    end else begin
      fifo_vld_q <= fifo_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
    end
  end

  // FIFO payload storage; contents only observed through valid slots
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]  <= wb_if.lu_rd;
      fifo_dat_q[wr_ptr_q] <= wb_if.lu_data;
    end
  end

  // destinations still owed by the late unit, for the hazard unit
  always_comb begin
    wb_if.lu_pending_mask = 32'd0;
    for (int i = 0; i < LU_DEPTH; i++) begin
      if (fifo_vld_q[i]) wb_if.lu_pending_mask[fifo_rd_q[i]] = 1'b1;
    end
  end

  // write-port arbitration: pipeline first, then FIFO head, else idle
  always_comb begin
    wb_if.writeback_control = 1'b0;
    wb_if.rd                = 5'd0;
    wb_if.writeback_data    = 32'd0;
    if (pipe_owns) begin
      wb_if.writeback_control = 1'b1;
      wb_if.rd                = rd_q;
      wb_if.writeback_data    = result;
    end else if (!fifo_empty) begin
      wb_if.writeback_control = 1'b1;
      wb_if.rd                = fifo_rd_q[rd_ptr_q];
      wb_if.writeback_data    = fifo_dat_q[rd_ptr_q];
    end
  end
endmodule
